// File: rtl/rv_pkg.sv
// Shared constants for the single-cycle RV32I core: opcodes, ALU op codes
// and the canonical NOP word used to fill unloaded ROM locations.
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // alu_op = {instr[30] (R-type / shift-imm only), funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/riscv_single_cycle_core_alu.sv
// Combinational RV32I ALU. 32-bit wraparound arithmetic, shifts by b[4:0],
// unrecognised op codes produce zero.
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);

  // result select by op code
  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_single_cycle_core_regs.sv
// 32 x 32 register file: two combinational read ports, one synchronous
// write port. x0 reads as zero and ignores writes. Not reset, so the
// contents can be preloaded from outside.
module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] reg_array [0:31];

  // write port; a same-edge read still sees the old value
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) reg_array[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_array[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_array[ra2];

endmodule

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I core (R-type and I-type ALU instructions). Fetch,
// decode, register read, ALU and writeback all happen in one clock; there
// are no branches, PC simply advances by 4.
// Optional macro RV_UTYPE_EN adds LUI and AUIPC; without it they are NOPs.
module riscv_single_cycle_core
  import rv_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter     IMEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_instr,
  output logic [3:0]  dbg_alu_op,
  output logic [31:0] dbg_alu_out
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef logic [31:0] rom_t [IMEM_DEPTH];

  function automatic rom_t rom_image();
    rom_t img;
    for (int i = 0; i < IMEM_DEPTH; i++) img[i] = NOP_INSTR;
    if (IMEM_INIT == "") begin
      img[0] = 32'h00408193;  // addi x3,x1,4
      img[1] = 32'h00208233;  // add  x4,x1,x2
      img[2] = 32'h00218293;  // addi x5,x3,2
      img[3] = 32'hFF800313;  // addi x6,x0,-8
      img[4] = 32'h00630393;  // addi x7,x6,6
    end
    return img;
  endfunction

  logic [31:0] rom [IMEM_DEPTH] = rom_image();

  // pc starts at zero so the datapath is meaningful before the first edge
  logic [31:0] pc = 32'd0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] rs1_value, rs2_value;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        rd_we;
`ifdef RV_UTYPE_EN
  logic [31:0] imm_u;
`endif

  // PC register: synchronous reset, otherwise sequential fetch
  always_ff @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else     pc <= pc + 32'd4;
  end

  assign instr  = rom[pc[AW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
`ifdef RV_UTYPE_EN
  assign imm_u  = {instr[31:12], 12'd0};
`endif

  // decode: operand selection, ALU op and writeback enable
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = rs1_value;
    alu_b  = imm_i;
    rd_we  = 1'b0;
    case (opcode)
      OP_R: begin
        alu_b  = rs2_value;
        alu_op = {instr[30], funct3};
        rd_we  = 1'b1;
      end
      OP_IMM: begin
        // instr[30] only distinguishes SRAI from SRLI; for other
        // immediates it is an immediate bit and must be ignored
        alu_op = {((funct3 == 3'b001) || (funct3 == 3'b101)) ? instr[30] : 1'b0,
                  funct3};
        rd_we  = 1'b1;
      end
`ifdef RV_UTYPE_EN
      OP_LUI: begin
        alu_a = 32'd0;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
      OP_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  reg_file regs (
    .clk (clk),
    .we  (rd_we && !rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .wd  (alu_out),
    .rd1 (rs1_value),
    .rd2 (rs2_value)
  );

  rv_alu alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_out)
  );

  assign dbg_pc      = pc;
  assign dbg_instr   = instr;
  assign dbg_alu_op  = alu_op;
  assign dbg_alu_out = alu_out;

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Directed bench for riscv_single_cycle_core: default program, mid-run
// reset, a second program covering SUB/SLT/SLTU/SRAI/XOR, x0 writes,
// unknown opcodes and (macro-dependent) LUI/AUIPC.
module tb_riscv_single_cycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dbg_pc, dbg_instr, dbg_alu_out;
  logic [3:0]  dbg_alu_op;

  int n_assert = 0;
  int n_fail   = 0;

  riscv_single_cycle_core dut (
    .clk         (clk),
    .rst         (rst),
    .dbg_pc      (dbg_pc),
    .dbg_instr   (dbg_instr),
    .dbg_alu_op  (dbg_alu_op),
    .dbg_alu_out (dbg_alu_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_def [4] = '{32'h3, 32'h7, 32'hFFFFFFF8, 32'hFFFFFFFE};

  logic [31:0] prog_b [10] = '{
    32'h40940533,  // sub  x10,x8,x9
    32'h009425B3,  // slt  x11,x8,x9
    32'h00943633,  // sltu x12,x8,x9
    32'h40245693,  // srai x13,x8,2
    32'h12345737,  // lui  x14,0x12345
    32'h00001797,  // auipc x15,1
    32'h00944833,  // xor  x16,x8,x9
    32'h00500013,  // addi x0,x0,5
    32'h0000000F,  // unknown opcode
    32'h0000088F   // unknown opcode, rd field = x17
  };
`ifdef RV_UTYPE_EN
  logic [9:0]  chk_b = 10'b00_1111_1111;
`else
  logic [9:0]  chk_b = 10'b00_1100_1111;
`endif
  logic [31:0] exp_b [10] = '{
    32'hFFFFFFED, 32'h1, 32'h0, 32'hFFFFFFFC,
    32'h12345000, 32'h00001014, 32'hFFFFFFF3, 32'h5,
    32'h0, 32'h0
  };

  initial begin
    for (int i = 0; i < 32; i++) dut.regs.reg_array[i] = 32'd0;
    dut.regs.reg_array[1] = 32'd1;
    dut.regs.reg_array[2] = 32'd2;
    #1;

    // before the first edge, no reset pulse
    check_val("pc0",        dbg_pc,        32'h0);
    check_val("instr0",     dbg_instr,     32'h00408193);
    check_val("rs1_value0", dut.rs1_value, 32'h1);
    check_val("alu_op0",    {28'd0, dbg_alu_op}, 32'h0);
    check_val("alu_out0",   dbg_alu_out,   32'h5);

    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) check_val("rs2_value_add", dut.rs2_value, 32'h2);
      check_val($sformatf("def_alu_out%0d", k + 1), dut.alu_out, exp_def[k]);
    end
    step();
    check_val("pc_after5", dbg_pc, 32'h14);
    check_val("x3", dut.regs.reg_array[3], 32'h5);
    check_val("x4", dut.regs.reg_array[4], 32'h3);
    check_val("x5", dut.regs.reg_array[5], 32'h7);
    check_val("x6", dut.regs.reg_array[6], 32'hFFFFFFF8);
    check_val("x7", dut.regs.reg_array[7], 32'hFFFFFFFE);
    check_val("x0", dut.regs.reg_array[0], 32'h0);

    // reset, rerun to pc=0x0C, then reset again mid-run
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("pc_reset", dbg_pc, 32'h0);
    for (int k = 0; k < 3; k++) step();
    check_val("pc_0c", dbg_pc, 32'h0C);
    dut.regs.reg_array[6] = 32'hDEADBEEF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("pc_midreset", dbg_pc, 32'h0);
    check_val("x6_no_write_in_reset", dut.regs.reg_array[6], 32'hDEADBEEF);
    check_val("x3_kept", dut.regs.reg_array[3], 32'h5);

    // second program
    for (int i = 0; i < 10; i++) dut.rom[i] = prog_b[i];
    dut.regs.reg_array[8]  = 32'hFFFFFFF0;
    dut.regs.reg_array[9]  = 32'h3;
    dut.regs.reg_array[14] = 32'h0000A5A5;
    dut.regs.reg_array[15] = 32'h00005A5A;
    dut.regs.reg_array[17] = 32'h00001717;
    #1;
    check_val("sub_alu_op",  {28'd0, dbg_alu_op}, 32'h8);
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("b_pc%0d", i), dbg_pc, 32'(4 * i));
      if (chk_b[i]) check_val($sformatf("b_alu_out%0d", i), dbg_alu_out, exp_b[i]);
      if (i == 3) check_val("srai_alu_op", {28'd0, dbg_alu_op}, 32'hD);
      step();
    end
    check_val("b_pc_end", dbg_pc, 32'h28);
    check_val("x10_sub",  dut.regs.reg_array[10], 32'hFFFFFFED);
    check_val("x11_slt",  dut.regs.reg_array[11], 32'h1);
    check_val("x12_sltu", dut.regs.reg_array[12], 32'h0);
    check_val("x13_srai", dut.regs.reg_array[13], 32'hFFFFFFFC);
    check_val("x16_xor",  dut.regs.reg_array[16], 32'hFFFFFFF3);
    check_val("x0_addi",  dut.regs.reg_array[0],  32'h0);
    check_val("x0_read",  dut.regs.rd1, 32'h0);
    check_val("x17_unknown_op", dut.regs.reg_array[17], 32'h00001717);
`ifdef RV_UTYPE_EN
    check_val("x14_lui",   dut.regs.reg_array[14], 32'h12345000);
    check_val("x15_auipc", dut.regs.reg_array[15], 32'h00001014);
`else
    check_val("x14_lui",   dut.regs.reg_array[14], 32'h0000A5A5);
    check_val("x15_auipc", dut.regs.reg_array[15], 32'h00005A5A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
